// File: rtl/scope_capture_if.sv
// Sample stream from the scaler plus the column read port used by the VGA renderer.
interface scope_capture_if #(
  parameter int AW = 10,
  parameter int DW = 8
);
  logic          sample_valid;
  logic [DW-1:0] sample_data;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;

  modport master (output sample_valid, sample_data, rd_addr, input rd_data);
  modport slave  (input sample_valid, sample_data, rd_addr, output rd_data);
endinterface

// File: rtl/scope_capture.sv
// Trigger-and-capture buffer: waits for a level crossing, records DEPTH samples into
// the back bank, and swaps it to the display side on the next vertical blank.
module scope_capture #(
  parameter int DEPTH   = 640,
  parameter int AW      = 10,
  parameter int DW      = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic          clk,
  input  logic          rst,
  scope_capture_if.slave bus,
  input  logic [DW-1:0] trig_level,
  input  logic          trig_falling,
  input  logic          run_mode,
  input  logic          auto_trig,
  input  logic          arm,
  input  logic          stop,
  input  logic          vblank,
  output logic          armed,
  output logic          capturing,
  output logic          frame_done,
  output logic          trig_forced,
  output logic [7:0]    frame_cnt
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(DEPTH);
  localparam logic [TW-1:0] TO_LAST   = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

  state_t        state_q, state_d;
  logic          disp_bank_q, disp_bank_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [DW-1:0] prev_q, prev_d;
  logic          prev_valid_q, prev_valid_d;
  logic          pend_forced_q, pend_forced_d;
  logic          trig_forced_q, trig_forced_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic [DW-1:0] rd_data_q, rd_data_d;

  logic          wr_en;
  logic [IW-1:0] wr_ptr;
  logic          hit_nat;
  logic          hit_forced;
  logic          swap;

  logic [DW-1:0] mem [2][DEPTH];

  always_comb begin
    state_d       = state_q;
    disp_bank_d   = disp_bank_q;
    wr_addr_d     = wr_addr_q;
    to_cnt_d      = to_cnt_q;
    prev_d        = prev_q;
    prev_valid_d  = prev_valid_q;
    pend_forced_d = pend_forced_q;
    trig_forced_d = trig_forced_q;
    frame_cnt_d   = frame_cnt_q;
    wr_en         = 1'b0;
    wr_ptr        = wr_addr_q[IW-1:0];
    swap          = 1'b0;
    hit_nat       = 1'b0;
    if (prev_valid_q) begin
      hit_nat = trig_falling ? (prev_q > trig_level && bus.sample_data <= trig_level)
                             : (prev_q < trig_level && bus.sample_data >= trig_level);
    end
    hit_forced = !hit_nat && auto_trig && (TIMEOUT != 0) && (to_cnt_q == TO_LAST);

    if (stop) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (arm) begin
            state_d      = S_ARMED;
            prev_valid_d = 1'b0;
            to_cnt_d     = '0;
          end
        end
        S_ARMED: begin
          if (bus.sample_valid) begin
            prev_d       = bus.sample_data;
            prev_valid_d = 1'b1;
            if (hit_nat || hit_forced) begin
              wr_en         = 1'b1;
              wr_ptr        = '0;
              wr_addr_d     = AW'(1);
              pend_forced_d = hit_forced;
              state_d       = S_CAPTURE;
            end else if (to_cnt_q != TO_LAST) begin
              // Holding at the last count keeps a late auto_trig enable meaningful.
              to_cnt_d = to_cnt_q + 1'b1;
            end
          end
        end
        S_CAPTURE: begin
          if (bus.sample_valid) begin
            wr_en     = 1'b1;
            wr_addr_d = wr_addr_q + 1'b1;
            if (wr_addr_q == LAST_ADDR) state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (vblank) begin
            swap          = 1'b1;
            disp_bank_d   = ~disp_bank_q;
            frame_cnt_d   = frame_cnt_q + 8'd1;
            trig_forced_d = pend_forced_q;
            state_d       = run_mode ? S_ARMED : S_IDLE;
            prev_valid_d  = 1'b0;
            to_cnt_d      = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    rd_data_d = '0;
    if ({1'b0, bus.rd_addr} < DEPTH_EXT) rd_data_d = mem[disp_bank_q][bus.rd_addr[IW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      disp_bank_q   <= 1'b0;
      wr_addr_q     <= '0;
      to_cnt_q      <= '0;
      prev_valid_q  <= 1'b0;
      pend_forced_q <= 1'b0;
      trig_forced_q <= 1'b0;
      frame_cnt_q   <= '0;
      rd_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      disp_bank_q   <= disp_bank_d;
      wr_addr_q     <= wr_addr_d;
      to_cnt_q      <= to_cnt_d;
      prev_valid_q  <= prev_valid_d;
      pend_forced_q <= pend_forced_d;
      trig_forced_q <= trig_forced_d;
      frame_cnt_q   <= frame_cnt_d;
      rd_data_q     <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    prev_q <= prev_d;
  end

  // Writes always land in the bank the renderer is not reading.
  always_ff @(posedge clk) begin
    if (wr_en) mem[~disp_bank_q][wr_ptr] <= bus.sample_data;
  end

  assign armed       = (state_q == S_ARMED);
  assign capturing   = (state_q == S_CAPTURE) || (state_q == S_DONE);
  assign frame_done  = swap && !rst;
  assign trig_forced = trig_forced_q;
  assign frame_cnt   = frame_cnt_q;
  assign bus.rd_data = rd_data_q;

endmodule

// File: tb/tb_scope_capture.sv
// Randomized bench for scope_capture: a reference model builds each expected record,
// a monitor pops it on frame_done and checks the display bank through the read port.
module tb_scope_capture;
  localparam int DEPTH = 8, AW = 4, DW = 8, TIMEOUT = 4;

  typedef struct packed {
    logic                  forced;
    logic [DEPTH*DW-1:0]   data;
  } frame_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] trig_level = '0;
  logic          trig_falling = 1'b0, run_mode = 1'b0, auto_trig = 1'b0;
  logic          arm = 1'b0, stop = 1'b0, vblank = 1'b0;
  logic          armed, capturing, frame_done, trig_forced;
  logic [7:0]    frame_cnt;

  scope_capture_if #(.AW(AW), .DW(DW)) bus ();

  scope_capture #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .trig_level(trig_level), .trig_falling(trig_falling), .run_mode(run_mode),
    .auto_trig(auto_trig), .arm(arm), .stop(stop), .vblank(vblank),
    .armed(armed), .capturing(capturing), .frame_done(frame_done),
    .trig_forced(trig_forced), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0, n_fail = 0;
  frame_t     exp_q[$];
  int         exp_cnt = 0;
  logic [7:0] stim_q[$];
  bit         idle = 1'b1;
  bit         noise = 1'b1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pick(input logic [7:0] level);
    int v;
    v = int'(level) + int'($urandom_range(0, 60)) - 30;
    if (v < 0) v = 0;
    if (v > 255) v = 255;
    return 8'(v);
  endfunction

  // One valid sample, optionally preceded by idle cycles carrying ignored arm/vblank noise.
  task automatic send(input logic [7:0] s, input bit vb);
    int gap;
    gap = noise ? int'($urandom_range(0, 2)) : 0;
    repeat (gap) begin
      cyc();
      bus.sample_valid = 1'b0;
      bus.sample_data  = 8'($urandom);
      vblank = noise && ($urandom_range(0, 7) == 0);
      arm    = noise && ($urandom_range(0, 7) == 0);
    end
    cyc();
    bus.sample_valid = 1'b1;
    bus.sample_data  = s;
    vblank = vb;
    arm    = 1'b0;
    cyc();
    bus.sample_valid = 1'b0;
    vblank = 1'b0;
    @(negedge clk);
  endtask

  task automatic acquire(input logic [7:0] level, input bit fall, input bit at, input bit rm,
                         input bit vb_last, input int stop_at, input int rst_at);
    logic [7:0] rec[$];
    logic [7:0] s, prevs;
    bit         prev_ok, nat, frc, forced;
    int         n, iter;
    frame_t     fr;
    trig_level = level; trig_falling = fall; auto_trig = at;
    prevs = '0; prev_ok = 1'b0; n = 0; forced = 1'b0; iter = 0;
    if (idle) begin
      cyc(); arm = 1'b1;
      cyc(); arm = 1'b0;
      @(negedge clk);
      check("armed_after_arm", armed, 1);
      check("capturing_after_arm", capturing, 0);
      idle = 1'b0;
    end
    while (rec.size() < DEPTH) begin
      iter++;
      if (iter > 500) begin
        n_cmp++; n_fail++;
        $display("FAIL trigger_budget: no trigger after %0d samples, expected one", iter);
        return;
      end
      s = (stim_q.size() > 0) ? stim_q.pop_front() : pick(level);
      if (rec.size() == 0) begin
        nat = prev_ok && (fall ? (prevs > level && s <= level) : (prevs < level && s >= level));
        frc = !nat && at && (TIMEOUT != 0) && (n == TIMEOUT - 1);
        if (nat || frc) begin rec.push_back(s); forced = frc; end
        else n++;
        prevs = s; prev_ok = 1'b1;
      end else begin
        rec.push_back(s);
      end
      send(s, vb_last && rec.size() == DEPTH);
      if (rec.size() == 0) check("armed_waiting", armed, 1);
      else check("capturing_in_record", capturing, 1);
      if (stop_at > 0 && rec.size() == stop_at) begin
        cyc(); stop = 1'b1; bus.sample_valid = 1'b1; bus.sample_data = 8'($urandom);
        cyc(); stop = 1'b0; bus.sample_valid = 1'b0;
        @(negedge clk);
        check("armed_after_stop", armed, 0);
        check("capturing_after_stop", capturing, 0);
        check("frame_cnt_after_stop", frame_cnt, exp_cnt & 255);
        idle = 1'b1;
        cyc(); vblank = 1'b1;
        cyc(); vblank = 1'b0;
        return;
      end
      if (rst_at > 0 && rec.size() == rst_at) begin
        cyc(); rst = 1'b1; bus.sample_valid = 1'b1;
        cyc(); rst = 1'b0; bus.sample_valid = 1'b0;
        @(negedge clk);
        check("rst_armed", armed, 0);
        check("rst_capturing", capturing, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_trig_forced", trig_forced, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        idle = 1'b1;
        return;
      end
    end
    check("armed_in_done", armed, 0);
    fr.forced = forced;
    for (int i = 0; i < DEPTH; i++) fr.data[i*DW +: DW] = rec[i];
    exp_q.push_back(fr);
    repeat (3) begin
      cyc(); bus.sample_valid = 1'b1; bus.sample_data = 8'($urandom);
    end
    cyc(); bus.sample_valid = 1'b0; vblank = 1'b1; run_mode = rm;
    cyc(); vblank = 1'b0;
    @(negedge clk);
    check("armed_after_swap", armed, int'(rm));
    check("capturing_after_swap", capturing, 0);
    idle = !rm;
  endtask

  // Monitor: pops the expected record on frame_done and checks every read result.
  initial begin : monitor
    logic [7:0] disp_mem [DEPTH];
    bit         disp_known, exp_forced, status_chk, cur_ok, prv_ok;
    int         a, sweep, cur_exp, prv_exp;
    frame_t     e;
    disp_known = 1'b0; exp_forced = 1'b0; status_chk = 1'b0;
    prv_ok = 1'b0; prv_exp = 0; sweep = DEPTH + 1;
    for (int i = 0; i < DEPTH; i++) disp_mem[i] = '0;
    bus.rd_addr = '0;
    forever begin
      @(posedge clk); #1;
      if (sweep <= DEPTH) begin a = sweep; sweep++; end
      else a = int'($urandom_range(0, DEPTH + 3));
      cur_ok  = (a >= DEPTH) || disp_known;
      cur_exp = (a >= DEPTH) ? 0 : int'(disp_mem[a]);
      bus.rd_addr = AW'(a);
      @(negedge clk);
      if (prv_ok) check("rd_data", bus.rd_data, prv_exp);
      if (rst) begin
        cur_ok = 1'b1; cur_exp = 0;
        disp_known = 1'b0; exp_cnt = 0; status_chk = 1'b0;
      end else begin
        if (status_chk) begin
          check("frame_cnt", frame_cnt, exp_cnt & 255);
          check("trig_forced", trig_forced, int'(exp_forced));
          status_chk = 1'b0;
        end
        if (frame_done) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_frame_done: got frame_done=1, expected 0 (t=%0t)", $time);
          end else begin
            e = exp_q.pop_front();
            for (int i = 0; i < DEPTH; i++) disp_mem[i] = e.data[i*DW +: DW];
            disp_known = 1'b1;
            exp_forced = e.forced;
            exp_cnt++;
            status_chk = 1'b1;
            sweep = 0;
          end
        end
      end
      prv_ok = cur_ok; prv_exp = cur_exp;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    bus.sample_valid = 1'b0;
    bus.sample_data  = '0;
    repeat (3) cyc();
    rst = 1'b0;
    @(negedge clk);
    check("reset_armed", armed, 0);
    check("reset_capturing", capturing, 0);
    check("reset_frame_done", frame_done, 0);
    check("reset_trig_forced", trig_forced, 0);
    check("reset_frame_cnt", frame_cnt, 0);

    // Rising edge at level 100: capture starts at 105.
    stim_q = '{8'd90, 8'd95, 8'd105, 8'd110, 8'd120, 8'd130, 8'd140, 8'd150, 8'd160, 8'd170};
    acquire(8'd100, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

    // Falling edge at 50: the leading 40 must not trigger; 45 does.
    stim_q = '{8'd40, 8'd60, 8'd45};
    acquire(8'd50, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);

    // Constant input with auto-trigger: forced on the 4th sample, re-arms afterwards.
    stim_q.delete();
    repeat (12) stim_q.push_back(8'd10);
    acquire(8'd100, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);

    // Constant input without auto-trigger never leaves ARMED.
    auto_trig = 1'b0; trig_level = 8'd100; trig_falling = 1'b0;
    repeat (20) begin
      send(8'd10, 1'b0);
      check("armed_no_auto", armed, 1);
    end
    cyc(); stop = 1'b1;
    cyc(); stop = 1'b0;
    @(negedge clk);
    check("armed_after_stop_idle", armed, 0);
    idle = 1'b1;

    // vblank coinciding with the last write is ignored; the following one swaps.
    acquire(8'd120, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);

    // Stop in the middle of a capture.
    acquire(8'd80, 1'b0, 1'b0, 1'b1, 1'b0, 3, 0);

    for (int k = 0; k < 6; k++) begin
      acquire(8'(30 + $urandom_range(0, 190)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'b0, 0, 0);
    end

    // Reset mid-capture, then a normal single-shot acquisition.
    if (!idle) begin
      cyc(); stop = 1'b1;
      cyc(); stop = 1'b0;
      idle = 1'b1;
    end
    acquire(8'd128, 1'b1, 1'b0, 1'b0, 1'b0, 0, 4);
    acquire(8'd128, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

    repeat (3 * DEPTH) cyc();
    @(negedge clk);
    check("frames_pending", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/scope_capture.md
Name: scope_capture

Overview:
- Trigger-and-capture buffer directly downstream of the ADC-to-VGA scaler.
- Consumes the scaler's 8-bit vertical-position samples and waits for a level-crossing trigger, then captures one screen-width record.
- Holds the record in a double-buffered RAM so the VGA renderer can read one sample per pixel column without tearing.
- The buffer swap occurs only on a vertical-blank pulse.

Parameters:
- DEPTH, 640: samples per record, one per display column.
- AW, 10: address width, with 2^AW >= DEPTH.
- DW, 8: sample width, matching the scaler output.
- TIMEOUT, 4096: valid samples spent in ARMED before an auto-trigger is forced. A value of 0 disables auto-trigger.

Ports:
- clk  in  1  system clock; the block has one clock.
- rst  in  1  reset, synchronous, active-high.
- sample_valid  in  1  strobe qualifying sample_data for one cycle.
- sample_data  in  DW  scaled sample from the scaler.
- trig_level  in  DW  trigger threshold.
- trig_falling  in  1  0 selects rising-edge trigger, 1 selects falling-edge trigger.
- run_mode  in  1  1 re-arms automatically after each swap; 0 selects single-shot.
- auto_trig  in  1  1 enables the forced trigger after TIMEOUT.
- arm  in  1  pulse; starts acquisition when the block is in IDLE.
- stop  in  1  pulse; aborts acquisition and returns the block to IDLE.
- vblank  in  1  one-cycle pulse at the start of vertical blank.
- rd_addr  in  AW  display column address.
- rd_data  out  DW  sample from the display bank, registered.
- armed  out  1  high while in ARMED.
- capturing  out  1  high while in CAPTURE or DONE.
- frame_done  out  1  one-cycle pulse in the cycle the banks swap.
- trig_forced  out  1  high when the displayed frame was auto-triggered.
- frame_cnt  out  8  count of completed swaps; wraps from 255 to 0.

Behaviour:
- Reset: state=IDLE, disp_bank=0, wr_addr=0, timeout counter=0, prev_valid=0. All outputs are 0. RAM contents are not cleared.
- States:
  - IDLE, ARMED, CAPTURE, DONE.
  - stop takes any state to IDLE. The partial record is discarded, and disp_bank, frame_cnt and trig_forced are unchanged.
  - stop has priority over all other events in the same cycle.
- IDLE:
  - arm moves the block to ARMED and clears prev_valid and the timeout counter.
  - arm is ignored in all other states.
- ARMED:
  - Each sample_valid cycle compares the sample with prev (the last valid sample), then loads prev and sets prev_valid.
  - Rising trigger: prev_valid and prev < trig_level and sample_data >= trig_level.
  - Falling trigger: prev_valid and prev > trig_level and sample_data <= trig_level.
  - The first valid sample after arming never triggers.
  - Forced trigger: auto_trig=1, TIMEOUT!=0, and the timeout counter equals TIMEOUT-1 on a valid sample that did not trigger naturally.
  - On either trigger, the triggering sample is written to back-bank address 0, wr_addr becomes 1, and the state moves to CAPTURE.
  - The forced flag is latched into a pending-forced register.
  - The timeout counter increments only on valid non-triggering samples.
- CAPTURE:
  - Each valid sample is written to back-bank[wr_addr] and wr_addr increments.
  - The write at address DEPTH-1 moves the state to DONE.
  - A vblank during CAPTURE is ignored, including in the cycle of the last write.
- DONE:
  - Samples are ignored.
  - On the first vblank:
    - disp_bank toggles and frame_done pulses.
    - frame_cnt increments and trig_forced is loaded from pending-forced.
    - The next state is ARMED if run_mode=1, otherwise IDLE.
  - run_mode is sampled in the vblank cycle.
- Read port:
  - rd_data is updated every cycle from disp_bank[rd_addr], with 1-cycle latency.
  - When rd_addr >= DEPTH, rd_data=0.
  - A swap takes effect for reads issued in the cycle after frame_done.
- Write and read never target the same bank.

Test Plan:
- Rising trigger:
  - Stimulus: DEPTH=8 (bench override), trig_level=100; arm, then feed valid samples 90, 95, 105, 110, 120, ...
  - Response: capture starts at 105, CAPTURE lasts 8 valid samples, DONE is reached, then vblank gives frame_done=1; next-cycle reads of addresses 0..7 return 105, 110, 120, ...; frame_cnt=1, trig_forced=0.
- Falling trigger and first-sample rule:
  - Stimulus: trig_falling=1, trig_level=50; the first sample after arm is 40, followed by 60 and 45.
  - Response: no trigger on 40; trigger on 45, which is stored at address 0.
- Auto-trigger:
  - Stimulus: TIMEOUT=4, auto_trig=1; feed constant samples of 10.
  - Response: forced trigger on the 4th valid sample, and trig_forced=1 after the swap.
  - With auto_trig=0, the block stays ARMED indefinitely.
- Vblank timing:
  - Stimulus: vblank coincides with the last CAPTURE write.
  - Response: no swap; the swap happens on the next vblank.
  - During CAPTURE, the display bank still returns the prior frame.
- Stop and single-shot:
  - Stimulus: stop mid-CAPTURE.
  - Response: IDLE, no frame_done, frame_cnt unchanged.
  - Stimulus: run_mode=0 and a full capture.
  - Response: IDLE after the swap; arm is needed to restart.
- Reset mid-operation:
  - Stimulus: rst in CAPTURE.
  - Response: all outputs are 0 the next cycle, disp_bank=0, and a subsequent arm works normally.
  - Stimulus: rd_addr=DEPTH.
  - Response: rd_data=0.
